kasumi_fi_seq: RTL and testbench



---
 rtl/kasumi_fi_seq.sv | 114 +++++++++++
 tb/tb_kasumi_fi_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/kasumi_fi_seq.sv
// KASUMI FI sequencer: two S9/S7 rounds over external ROMs, valid/ready in and out.
// Define KASUMI_FI_SYNC_ROM_EN for ROMs with one cycle of read latency (2-cycle lookups).
module kasumi_fi_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [15:0] in_ki,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [6:0]  s7_addr,
  input  logic [6:0]  s7_data,
  output logic [8:0]  s9_addr,
  input  logic [8:0]  s9_data
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] L9A  = 3'd1;
  localparam logic [2:0] L7A  = 3'd2;
  localparam logic [2:0] L9B  = 3'd3;
  localparam logic [2:0] L7B  = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]  r_state;
  logic [8:0]  r_nine;
  logic [6:0]  r_seven;
  logic [15:0] r_ki;
  logic        w_lookup;
  logic        w_sample;

  assign w_lookup = (r_state == L9A) || (r_state == L7A) ||
                    (r_state == L9B) || (r_state == L7B);

`ifdef KASUMI_FI_SYNC_ROM_EN
  // First cycle of a lookup presents the address, second cycle consumes the data.
  logic r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= 1'b0;
    end else if (w_lookup) begin
      r_phase <= ~r_phase;
    end else begin
      r_phase <= 1'b0;
    end
  end

  assign w_sample = r_phase;
`else
  assign w_sample = w_lookup;
`endif

  // Addresses follow the working registers, so they stay put until the sample cycle.
  assign s9_addr   = r_nine;
  assign s7_addr   = r_seven;
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = (r_state == DONE) ? {r_seven, r_nine} : 16'h0000;

  // NOTE: non-blocking assignments let L7A read the pre-update nine while also rewriting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_nine  <= 9'd0;
      r_seven <= 7'd0;
      r_ki    <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_nine  <= in_data[15:7];
            r_seven <= in_data[6:0];
            r_ki    <= in_ki;
            r_state <= L9A;
          end
        end
        L9A: begin
          if (w_sample) begin
            r_nine  <= s9_data ^ {2'b00, r_seven};
            r_state <= L7A;
          end
        end
        L7A: begin
          if (w_sample) begin
            r_seven <= s7_data ^ r_nine[6:0] ^ r_ki[15:9];
            r_nine  <= r_nine ^ r_ki[8:0];
            r_state <= L9B;
          end
        end
        L9B: begin
          if (w_sample) begin
            r_nine  <= s9_data ^ {2'b00, r_seven};
            r_state <= L7B;
          end
        end
        L7B: begin
          if (w_sample) begin
            r_seven <= s7_data ^ r_nine[6:0];
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kasumi_fi_seq.sv
// Scoreboard bench for kasumi_fi_seq: real S7 table, identity S9, directed vectors.
module tb_kasumi_fi_seq;

`ifdef KASUMI_FI_SYNC_ROM_EN
  localparam int LAT    = 9;
  localparam int PERIOD = 10;
  localparam int ABORT  = 5;
`else
  localparam int LAT    = 5;
  localparam int PERIOD = 6;
  localparam int ABORT  = 2;
`endif

  localparam logic [6:0] S7 [128] = '{
     54, 50, 62, 56, 22, 34, 94, 96, 38,  6, 63, 93,  2, 18,123, 33,
     55,113, 39,114, 21, 67, 65, 12, 47, 73, 46, 27, 25,111,124, 81,
     53,  9,121, 79, 52, 60, 58, 48,101,127, 40,120,104, 70, 71, 43,
     20,122, 72, 61, 23,109, 13,100, 77,  1, 16,  7, 82, 10,105, 98,
    117,116, 76, 11, 89,106,  0,125,118, 99, 86, 69, 30, 57,126, 87,
    112, 51, 17,  5, 95, 14, 90, 84, 91,  8, 35,103, 32, 97, 28, 66,
    102, 31, 26, 45, 75,  4, 85, 92, 37, 74, 80, 49, 68, 29,115, 44,
     64,107,108, 24,110, 83, 36, 78, 42, 19, 15, 41, 88,119, 59,  3
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic [15:0] in_ki = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [6:0]  s7_addr;
  logic [6:0]  s7_data;
  logic [8:0]  s9_addr;
  logic [8:0]  s9_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int prev_acc_cyc = 0;
  bit pending = 1'b0;
  logic [15:0] exp_q [$];

  kasumi_fi_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ki(in_ki),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .s7_addr(s7_addr), .s7_data(s7_data), .s9_addr(s9_addr), .s9_data(s9_data)
  );

  always #5 clk = ~clk;

`ifdef KASUMI_FI_SYNC_ROM_EN
  always @(posedge clk) begin
    s7_data <= S7[s7_addr];
    s9_data <= s9_addr;
  end
`else
  assign s7_data = S7[s7_addr];
  assign s9_data = s9_addr;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each result handshake.
  always @(negedge clk) begin
    if (rst) begin
      pending = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        pending      = 1'b1;
        prev_acc_cyc = acc_cyc;
        acc_cyc      = cyc;
      end
      if (out_valid && pending) begin
        check("latency", cyc - acc_cyc, LAT);
        pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        else check("out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a request; push the expected result once acceptance is certain.
  task automatic send(input logic [15:0] d, input logic [15:0] k, input logic [15:0] exp,
                      input bit push);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_ki    = k;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) exp_q.push_back(exp);
        done = 1'b1;
      end
      next_cycle();
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    next_cycle();
  endtask

  initial begin
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {16'd0, out_data},  32'd0);
    check("rst_s7_addr",   {25'd0, s7_addr},   32'd0);
    check("rst_s9_addr",   {23'd0, s9_addr},   32'd0);
    next_cycle();

    send(16'h0000, 16'h0000, 16'h7636, 1'b1);
    wait_drain();
    send(16'h0000, 16'hFFFF, 16'hABB6, 1'b1);
    wait_drain();
    send(16'h1234, 16'h0000, 16'hEE17, 1'b1);
    wait_drain();

    // Back-to-back with out_ready high: accept spacing is one full period.
    send(16'h0000, 16'h0000, 16'h7636, 1'b1);
    send(16'h1234, 16'h0000, 16'hEE17, 1'b1);
    wait_drain();
    check("period", acc_cyc - prev_acc_cyc, PERIOD);

    // Consumer stall in DONE.
    out_ready = 1'b0;
    send(16'h0000, 16'hFFFF, 16'hABB6, 1'b1);
    for (int i = 0; i < 50 && !out_valid; i++) next_cycle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_out_data",  {16'd0, out_data},  32'h0000ABB6);
      check("stall_in_ready",  {31'd0, in_ready},  32'd0);
      next_cycle();
    end
    out_ready = 1'b1;
    wait_drain();

    // A request presented while busy is ignored.
    send(16'h0000, 16'hFFFF, 16'hABB6, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    in_ki    = 16'h5555;
    @(negedge clk);
    check("busy_in_ready", {31'd0, in_ready}, 32'd0);
    next_cycle();
    in_valid = 1'b0;
    wait_drain();

    // Abort mid-operation; nothing is expected from the aborted request.
    send(16'h0000, 16'hFFFF, 16'hABB6, 1'b0);
    for (int i = 0; i < ABORT; i++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready",  {31'd0, in_ready},  32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out_data",  {16'd0, out_data},  32'd0);
    next_cycle();
    send(16'h0000, 16'h0000, 16'h7636, 1'b1);
    wait_drain();

    for (int i = 0; i < 5; i++) next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
